seq_detect_multi: RTL

//  Parametrised serial bit-pattern detector: NUM_PAT runtime-programmable patterns of up
//  to MAX_LEN bits each, checked against one input bit stream qualified by in_valid.

---
 rtl/seq_detect_multi_if.sv | 33 +++
 rtl/seq_detect_multi.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_detect_multi_if.sv
// Bus bundle for seq_detect_multi: serial sample input, slot configuration,
// counter control and the registered match status returned to the consumer.
interface seq_detect_multi_if #(
  parameter int MAX_LEN = 8,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = 1,
  parameter int LEN_W   = 4
);
  logic               in_valid;
  logic               in_bit;
  logic               mode_overlap;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cnt_clr;
  logic               out;
  logic [NUM_PAT-1:0] match_id;
  logic [CNT_W-1:0]   match_cnt;

  // Front end / controller side: drives samples and configuration.
  modport master (
    output in_valid, in_bit, mode_overlap, cfg_we, cfg_idx, cfg_pat, cfg_len, cnt_clr,
    input  out, match_id, match_cnt
  );

  // Detector side.
  modport slave (
    input  in_valid, in_bit, mode_overlap, cfg_we, cfg_idx, cfg_pat, cfg_len, cnt_clr,
    output out, match_id, match_cnt
  );
endinterface

// File: rtl/seq_detect_multi.sv
// Multi-pattern serial bit detector. Each slot holds a pattern of up to MAX_LEN
// bits (bit 0 = newest) and compares it against the incoming bit plus history.
// A fill counter guarantees a slot only fires once it has seen len genuine bits,
// so reset zeros in the history never produce a hit. In non-overlapping mode a
// hit empties the fill so no bit of a matched sequence is reused.
module seq_detect_multi #(
  parameter int MAX_LEN = 8,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = 1,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_multi_if.slave  bus
);

  localparam int                WIN_W    = MAX_LEN + 1;
  localparam int                CMP_W    = LEN_W + 1;
  localparam logic [LEN_W-1:0]  FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Slot configuration table.
  logic [MAX_LEN-1:0] pat_q [NUM_PAT];
  logic [MAX_LEN-1:0] pat_d [NUM_PAT];
  logic [LEN_W-1:0]   len_q [NUM_PAT];
  logic [LEN_W-1:0]   len_d [NUM_PAT];

  // Stream history and number of genuine bits it holds.
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // Registered status.
  logic               out_q, out_d;
  logic [NUM_PAT-1:0] match_id_q, match_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Compare datapath.
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   mask;
  logic [CMP_W-1:0]   avail;
  logic [NUM_PAT-1:0] hit;
  logic               any_hit;

  // Per-slot match of the low len bits of {hist, in_bit} against the stored pattern.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    win   = {hist_q, bus.in_bit};
    mask  = '0;
    avail = CMP_W'(fill_q) + CMP_W'(1);
    hit   = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      // Ones in the low len positions; pattern bits above len-1 are don't-care.
      mask = ~({WIN_W{1'b1}} << len_q[i]);
      if (bus.in_valid
          && (len_q[i] != '0)
          && (len_q[i] <= FILL_MAX)
          && (avail >= CMP_W'(len_q[i]))
          && ((win & mask) == ({1'b0, pat_q[i]} & mask))) begin
        hit[i] = 1'b1;
      end
    end
    any_hit = |hit;
  end

  // Next state for history, fill, status, counter and slot configuration.
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    out_d      = any_hit;
    match_id_d = hit;
    cnt_d      = cnt_q;

    if (bus.in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], bus.in_bit};
      if (!bus.mode_overlap && any_hit) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    // Clear wins over a coincident hit; the count sticks at all-ones.
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (any_hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // An out-of-range cfg_idx matches no slot, so the write is dropped. The
    // compare above reads the _q values, so a same-cycle sample sees the old config.
    for (int i = 0; i < NUM_PAT; i++) begin
      pat_d[i] = pat_q[i];
      len_d[i] = len_q[i];
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
        pat_d[i] = bus.cfg_pat;
        len_d[i] = bus.cfg_len;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      hist_q     <= '0;
      fill_q     <= '0;
      out_q      <= 1'b0;
      match_id_q <= '0;
      cnt_q      <= '0;
      // NOTE: the slot table is reset on purpose; a slot that is disabled
      // out of reset is part of the block's behaviour, not just initialisation.
      for (int i = 0; i < NUM_PAT; i++) begin
        pat_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      out_q      <= out_d;
      match_id_q <= match_id_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < NUM_PAT; i++) begin
        pat_q[i] <= pat_d[i];
        len_q[i] <= len_d[i];
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.match_id  = match_id_q;
  assign bus.match_cnt = cnt_q;

endmodule
